// File: rtl/pktdepad.sv
// Removes block padding from a 64-bit packet stream, emitting only the message data packets.
// Define PKTDEPAD_CHECK_EN to enable padding/length checking and the err output.
module pktdepad (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pkt_in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] pkt_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done,
  output logic        err
);
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned PW    = 4;
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned CW    = 58;

  typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d, rd_q, rd_d, wr_q, wr_d, drain_q, drain_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            in_fire, out_fire, push, pop, last_fire, chk_err;
  logic [PW-1:0]   cnt_eff, drain_calc;
  logic [CW-1:0]   out_eff, r_len;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (state_q == S_COLLECT) && ((cnt_q < PW'(DEPTH)) || out_ready);
  assign out_valid = ((state_q == S_COLLECT) && (cnt_q == PW'(DEPTH))) ||
                     ((state_q == S_DRAIN) && (drain_q != '0));
  assign out_last  = (state_q == S_DRAIN) && (drain_q == PW'(1));
  assign pkt_out   = out_valid ? mem_q[rd_q] : '0;
  assign done      = (state_q == S_DONE);

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign push      = in_fire & ~in_last;
  assign pop       = out_fire;
  assign last_fire = in_fire & in_last;

  // FIFO view as of the length packet, counting any pop in the same cycle
  assign cnt_eff    = cnt_q - PW'(pop);
  assign out_eff    = out_cnt_q + CW'(pop);
  assign r_len      = pkt_in[DW-1:6] - out_eff;
  assign drain_calc = (r_len < CW'(cnt_eff)) ? r_len[PW-1:0] : cnt_eff;

`ifdef PKTDEPAD_CHECK_EN
  localparam logic [DW-1:0] PAD_PKT = 64'h8000_0000_0000_0000;

  logic [CW-1:0] tot_q, tot_d, tot_plus, p_len;
  logic          err_q, err_d, pad_bad;
  logic [PW-1:0] pos;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input logic [PW-1:0] off);
    logic [SW-1:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= SW'(DEPTH)) ? PW'(s - SW'(DEPTH)) : PW'(s);
  endfunction

  // Entries past the R data packets must be one pad packet then zeros
  always_comb begin
    tot_plus = tot_q + CW'(1);
    p_len    = CW'(cnt_eff) - r_len;
    pad_bad  = 1'b0;
    pos      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = PW'(k) - PW'(pop);
      if ((PW'(k) >= PW'(pop)) && (pos < cnt_eff)) begin
        if (CW'(pos) == r_len)
          pad_bad = pad_bad | (mem_q[wrap_idx(rd_q, PW'(k))] != PAD_PKT);
        else if (CW'(pos) > r_len)
          pad_bad = pad_bad | (mem_q[wrap_idx(rd_q, PW'(k))] != '0);
      end
    end
    chk_err = (pkt_in[5:0] != '0) || (p_len == '0) || (p_len > CW'(8)) || pad_bad ||
              (tot_plus[2:0] != '0);

    tot_d = tot_q;
    err_d = err_q;
    if (state_q == S_DONE) begin
      tot_d = '0;
      err_d = 1'b0;
    end else if (in_fire) begin
      tot_d = tot_plus;
      if (last_fire) err_d = chk_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  assign err = done & err_q;
`else
  assign chk_err = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    drain_d   = drain_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      S_COLLECT: begin
        if (push) wr_d = ptr_inc(wr_q);
        if (pop)  rd_d = ptr_inc(rd_q);
        cnt_d     = cnt_q + PW'(push) - PW'(pop);
        out_cnt_d = out_eff;
        if (last_fire) begin
          state_d = S_DRAIN;
          drain_d = chk_err ? '0 : drain_calc;
        end
      end
      S_DRAIN: begin
        if (pop) begin
          rd_d      = ptr_inc(rd_q);
          cnt_d     = cnt_q - PW'(1);
          drain_d   = drain_q - PW'(1);
          out_cnt_d = out_eff;
        end
        if ((drain_q == '0) || ((drain_q == PW'(1)) && pop)) state_d = S_DONE;
      end
      default: begin
        // Leftover padding is dropped by clearing the FIFO bookkeeping
        state_d   = S_COLLECT;
        cnt_d     = '0;
        rd_d      = '0;
        wr_d      = '0;
        drain_d   = '0;
        out_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      drain_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      drain_q   <= drain_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pkt_in;
  end
endmodule

// File: tb/tb_pktdepad.sv
// Scoreboard bench for pktdepad: random padded messages against a message-level reference model.
module tb_pktdepad;
  localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;
`ifdef PKTDEPAD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pkt_in;
  logic        in_valid, in_last, in_ready;
  logic [63:0] pkt_out;
  logic        out_valid, out_ready, out_last, done, err;

  always #5 clk = ~clk;

  pktdepad dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .pkt_out(pkt_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .done(done), .err(err)
  );

  typedef struct { logic [63:0] data; logic last; } exp_t;
  exp_t        exp_q[$];
  logic        exp_err_q[$];
  logic [63:0] msg_q[$];
  int          total = 0;
  int          bad   = 0;
  int          or_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every output transfer and done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got %0h expected none", pkt_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", pkt_out, e.data);
          check("out_last", 64'(out_last), 64'(e.last));
        end
      end
      if (done) begin
        if (exp_err_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          logic ee;
          ee = exp_err_q.pop_front();
          check("done_err", 64'(err), 64'(ee));
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = 1'($urandom_range(0, 1));
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Error rules evaluated on the whole message (non-length packets in msg_q)
  function automatic logic model_err(input logic [63:0] len);
    int  nl, n, p;
    logic e;
    nl = msg_q.size();
    n  = int'(len >> 6);
    p  = nl - n;
    e  = (len[5:0] != 6'd0) || (p < 1) || (p > 8) || (((nl + 1) % 8) != 0);
    if (p >= 1 && p <= 8) begin
      if (msg_q[n] != PAD) e = 1'b1;
      for (int i = n + 1; i < nl; i++) if (msg_q[i] != 64'd0) e = 1'b1;
    end
    return e;
  endfunction

  task automatic send(input logic [63:0] d, input logic l);
    int   w;
    logic acc;
    if ($urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; pkt_in = d; in_last = l; w = 0; acc = 1'b0;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      w++;
      if (!acc && w > 3000) begin
        total++; bad++;
        $display("FAIL send_timeout: got in_ready=0 expected 1");
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_msg(input logic [63:0] len);
    int   nl, n, nout;
    logic e;
    nl   = msg_q.size();
    n    = int'(len >> 6);
    e    = CHK && model_err(len);
    nout = e ? 0 : ((n < nl) ? n : nl);
    for (int i = 0; i < nout; i++) exp_q.push_back('{msg_q[i], (i == nout - 1)});
    exp_err_q.push_back(e);
    for (int i = 0; i < nl; i++) send(msg_q[i], 1'b0);
    send(len, 1'b1);
    msg_q.delete();
  endtask

  // kind: 0 well-formed, 1 bad pad word, 2 nonzero fill word, 3 length low bits set
  task automatic build(input int d, input int kind);
    int z;
    z = ((6 - d) % 8 + 8) % 8;
    for (int i = 0; i < d; i++) msg_q.push_back({$urandom, $urandom});
    msg_q.push_back(kind == 1 ? 64'h4000_0000_0000_0000 : PAD);
    for (int i = 0; i < z; i++) msg_q.push_back(64'd0);
    if (kind == 2 && z > 0) msg_q[d + 1 + $urandom_range(0, z - 1)] = 64'h1 << $urandom_range(0, 63);
    run_msg(64'(d) * 64 + ((kind == 3) ? 64'd5 : 64'd0));
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || exp_err_q.size() != 0) && w < 500) begin
      @(posedge clk); #1; w++;
    end
  endtask

  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; pkt_in = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_pkt_out",   pkt_out,        64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    or_mode = 1;
    msg_q.push_back(64'hAAAA_0000_0000_0001); msg_q.push_back(64'hBBBB_0000_0000_0002);
    msg_q.push_back(64'hCCCC_0000_0000_0003); msg_q.push_back(PAD);
    repeat (3) msg_q.push_back(64'd0);
    run_msg(64'd192);
    build(7, 0);
    msg_q.push_back(PAD); msg_q.push_back(PAD);
    repeat (5) msg_q.push_back(64'd0);
    run_msg(64'd64);
    build(0, 0);
    msg_q.push_back(64'h1111); msg_q.push_back(64'h2222); msg_q.push_back(PAD);
    msg_q.push_back(64'd0); msg_q.push_back(64'h0000_0100_0000_0000);
    msg_q.push_back(64'd0); msg_q.push_back(64'd0);
    run_msg(64'd128);
    wait_drain();

    // Backpressure then reset with a full FIFO
    or_mode = 2;
    repeat (2) @(posedge clk);
    #1 acc = 0; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pkt_in = {$urandom, $urandom};
      @(negedge clk); if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted",  64'(acc),       64'd10);
    check("bp_in_ready",  64'(in_ready),  64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pkt_out",   pkt_out,         64'd0);
    check("mid_rst_done",      64'(done),       64'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready",  64'(in_ready),  64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    or_mode = 1;
    repeat (12) @(posedge clk);
    #1;
    build(3, 0);
    wait_drain();

    for (int m = 0; m < 40; m++) begin
      int kind;
      or_mode = $urandom_range(0, 1);
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (kind == 0) build($urandom_range(0, 24), 0);
      else           build($urandom_range(0, 5), kind);
    end
    wait_drain();
    check("leftover_out",  64'(exp_q.size()),     64'd0);
    check("leftover_done", 64'(exp_err_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
